// File: rtl/frame_pixel_unpacker_pkg.sv
// Shared definitions for the VLC receiver front end: FSM encodings, default
// frame geometry and the luma weighting shift.
package frame_pixel_unpacker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH     = 180;
  localparam int DEF_HEIGHT    = 350;
  localparam int DEF_CHANNELS  = 3;
  localparam int DEF_THRESHOLD = 90;

  // (R + 2G + B) has total weight 4, so the weighted sum is divided by 2^2.
  localparam int LUMA_SHIFT = 2;

  // Counter width that stays at least one bit for single-valued ranges.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_pixel_unpacker_rgb_to_gray.sv
// Collects the colour bytes of one pixel and presents its luma combinationally
// while the final channel byte is on the input.
module rgb_to_gray
  import frame_pixel_unpacker_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CW       = cnt_width(DEF_CHANNELS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          take,
  input  logic [CW-1:0] ch,
  input  logic [7:0]    datain,
  output logic [7:0]    gray
);

  if (CHANNELS == 1) begin : g_mono
    assign gray = datain;
  end else begin : g_rgb
    logic [7:0] r_q;
    logic [7:0] g_q;
    logic [7:0] b;
    logic [9:0] sum;

    // NOTE: the byte holders are reset so a pixel interrupted by reset can never
    // leak stale colour into the first pixel of the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
        g_q <= '0;
      end else if (take) begin
        if (ch == CW'(0)) r_q <= datain;
        if (ch == CW'(1)) g_q <= datain;
      end
    end

    if (CHANNELS == 4) begin : g_rgbx
      // Blue is not the last byte here (the pad byte is), so it must be held.
      logic [7:0] b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       b_q <= '0;
        else if (take && ch == CW'(2))    b_q <= datain;
      end
      assign b = b_q;
    end else begin : g_rgb3
      assign b = datain;
    end

    // 10 bits hold the worst case 4*255, so the sum never wraps.
    assign sum  = {2'b00, r_q} + {1'b0, g_q, 1'b0} + {2'b00, b};
    assign gray = 8'(sum >> LUMA_SHIFT);
  end

endmodule

// File: rtl/frame_pixel_unpacker.sv
// Camera byte stream to pixel converter: counts channel/x/y, builds luma and a
// thresholded bit, and marks frame start, end and aborted transfers.
module frame_pixel_unpacker
  import frame_pixel_unpacker_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int HEIGHT    = DEF_HEIGHT,
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int THRESHOLD = DEF_THRESHOLD,
  localparam int XW       = $clog2(WIDTH),
  localparam int YW       = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          din_valid,
  input  logic [7:0]    datain,
  output logic          pix_valid,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic [7:0]    pix_gray,
  output logic          pix_bit,
  output logic          sof,
  output logic          eof,
  output logic          frame_err,
  output logic          busy
);

  localparam int CW = cnt_width(CHANNELS);

  state_t        state, state_nxt;
  logic [CW-1:0] ch;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          take, last_ch, last_x, last_y;
  logic          pix_done, frame_last, abort;
  logic [7:0]    gray;

  // Bytes arriving in DONE are swallowed without effect.
  always_comb begin
    take       = start && din_valid && (state != ST_DONE);
    last_ch    = (ch == CW'(CHANNELS - 1));
    last_x     = (x == XW'(WIDTH - 1));
    last_y     = (y == YW'(HEIGHT - 1));
    pix_done   = take && last_ch;
    frame_last = pix_done && last_x && last_y;
    abort      = (state == ST_RUN) && !start;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        if (!start)          state_nxt = ST_IDLE;
        else if (frame_last) state_nxt = ST_DONE;
      end
      ST_DONE: if (!start) state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
  end

  // Channel/x/y counters; an abort or a completed frame rewinds them to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch <= '0;
      x  <= '0;
      y  <= '0;
    end else if (abort) begin
      ch <= '0;
      x  <= '0;
      y  <= '0;
    end else if (take) begin
      if (last_ch) begin
        ch <= '0;
        if (last_x) begin
          x <= '0;
          y <= last_y ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end else begin
        ch <= ch + 1'b1;
      end
    end
  end

  rgb_to_gray #(
    .CHANNELS (CHANNELS),
    .CW       (CW)
  ) u_rgb_to_gray (
    .clk    (clk),
    .rst_n  (rst_n),
    .take   (take),
    .ch     (ch),
    .datain (datain),
    .gray   (gray)
  );

  // Pixel fields hold between strobes; sof/eof/frame_err are single-cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_gray  <= '0;
      pix_bit   <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      pix_valid <= pix_done;
      sof       <= pix_done && (x == '0) && (y == '0);
      eof       <= frame_last;
      frame_err <= abort;
      if (pix_done) begin
        pix_x    <= x;
        pix_y    <= y;
        pix_gray <= gray;
        pix_bit  <= (int'(gray) >= THRESHOLD);
      end
    end
  end

endmodule
